// File: rtl/rr_pkt_arb.sv
// Round-robin packet arbiter: N ports share one registered output link, grant locked until TAIL.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module rr_pkt_arb #(
    parameter int unsigned N         = 4,
    parameter int unsigned FLIT_W    = 10,
    parameter int unsigned WD_CYCLES = 16,
    // Only the TAIL code matters here; HEAD and BODY flits are forwarded alike.
    parameter logic [1:0]  TAIL_TYPE = 2'b11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N-1:0]            req_i,
    input  logic [N*FLIT_W-1:0]     flit_in_i,
    input  logic [N-1:0]            flit_vld_i,
    output logic [N-1:0]            ackx_o,
    output logic [$clog2(N)-1:0]    grant_id_o,
    output logic [FLIT_W-1:0]       out_flit_o,
    output logic                    out_vld_o,
    output logic                    busy_o,
    output logic                    wd_err_o
);

    localparam int unsigned IdW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    gid_q, gid_d;
    logic [N-1:0]      ackx_q, ackx_d;
    logic [FLIT_W-1:0] oflit_q, oflit_d;
    logic              ovld_q, ovld_d;
    logic              wd_err_q, wd_err_d;

    logic              pick_found;
    logic [IdW-1:0]    pick_idx;
    logic [FLIT_W-1:0] gflit;
    logic              gvld;
    logic              gtail;
    logic [IdW-1:0]    ptr_next;

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin : arb_pick
        logic [IdW-1:0] idx;
        idx        = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IdW'((32'(ptr_q) + k) % N);
            if (!pick_found && req_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign gflit    = flit_in_i[32'(gid_q) * FLIT_W +: FLIT_W];
    assign gvld     = flit_vld_i[gid_q];
    assign gtail    = (gflit[FLIT_W-1 -: 2] == TAIL_TYPE);
    assign ptr_next = (gid_q == IdW'(N - 1)) ? '0 : gid_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        ackx_d   = ackx_q;
        oflit_d  = oflit_q;
        ovld_d   = 1'b0;
        wd_err_d = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StLock;
                    gid_d   = pick_idx;
                    ackx_d  = N'(1) << pick_idx;
`ifdef ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            StLock: begin
                if (gvld) begin
                    oflit_d = gflit;
                    ovld_d  = 1'b1;
`ifdef ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                    if (gtail) begin
                        state_d = StIdle;
                        ackx_d  = '0;
                        ptr_d   = ptr_next;
                    end
                end else begin
`ifdef ARB_WATCHDOG_EN
                    // This stalled cycle brings the count to WD_CYCLES: force release.
                    if (wd_cnt_q == WdW'(WD_CYCLES - 1)) begin
                        state_d  = StIdle;
                        ackx_d   = '0;
                        ptr_d    = ptr_next;
                        wd_err_d = 1'b1;
                        wd_cnt_d = '0;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            gid_q    <= '0;
            ackx_q   <= '0;
            oflit_q  <= '0;
            ovld_q   <= 1'b0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            ackx_q   <= ackx_d;
            oflit_q  <= oflit_d;
            ovld_q   <= ovld_d;
            wd_err_q <= wd_err_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
    assign wd_err_o = wd_err_q;
`else
    assign wd_err_o = 1'b0;
`endif

    assign ackx_o     = ackx_q;
    assign grant_id_o = gid_q;
    assign out_flit_o = oflit_q;
    assign out_vld_o  = ovld_q;
    assign busy_o     = (state_q == StLock);

endmodule

// File: doc/rr_pkt_arb.md
# rr_pkt_arb

Parametrised round-robin packet arbiter for the switch output stage: N input ports compete for one output link. A grant is locked for a whole packet and released only on the flit whose type field is `TAIL. The block then forwards the granted port's flits to a registered output and rotates priority. Successor to the fixed 4-port, single-cycle-ack arbiter: adds a generic port count, a real rotating pointer, packet lock and an optional stall watchdog.

## Interface
- N, 4, number of input ports (2..16)
- FLIT_W, 10, flit width; type field is flit[FLIT_W-1:FLIT_W-2], codes `HEAD/`BODY/`TAIL from sw.vh
- WD_CYCLES, 16, watchdog limit in cycles (used only with ARB_WATCHDOG_EN)
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  N  req[i] high: port i holds a packet head ready
- flit_in  in  N*FLIT_W  port i flit at bits [i*FLIT_W +: FLIT_W]
- flit_vld  in  N  flit_in slice i valid this cycle
- ackx  out  N  one-hot grant, registered; `ASSERT level while port owns the link
- grant_id  out  $clog2(N)  index of granted port; holds last value when idle
- out_flit  out  FLIT_W  forwarded flit, registered
- out_vld  out  1  out_flit valid
- busy  out  1  high in LOCK
- wd_err  out  1  one-cycle pulse on watchdog release

## Operation
- State: IDLE, LOCK. Pointer ptr (0..N-1) is the highest-priority port.
- IDLE: if any req, choose the first i with req[i] high, scanning ptr, ptr+1, ... mod N. Then ackx <= onehot(i), grant_id <= i, go to LOCK. If no req, stay in IDLE; ptr unchanged.
- LOCK: only the granted port is observed. Every other port's req and flit_vld is ignored.
  - If flit_vld[g]: out_flit <= slice g, out_vld <= 1. Otherwise out_vld <= 0.
  - If the accepted flit type is `TAIL: ackx <= 0, ptr <= (g+1) mod N, go to IDLE.
  - Dropping req[g] while in LOCK does not release the grant. Only `TAIL (or the watchdog) releases it.
- A single-flit packet whose only flit is `TAIL is granted and released normally.
- Type arithmetic: only bits [FLIT_W-1:FLIT_W-2] are compared. The payload is passed through unmodified.
- ptr wraps from N-1 to 0. A port that just finished has lowest priority for the next grant.

## Timing
- Reset values: state=IDLE, ptr=0, ackx=0, grant_id=0, out_flit=0, out_vld=0, busy=0, wd_err=0. Reset mid-packet aborts the packet and emits no flit.
- Grant latency: req sampled at edge t gives ackx/busy high after edge t.
- Forward latency: flit sampled at edge t gives out_flit/out_vld after edge t (1 cycle).
- Release: the `TAIL flit is sampled at edge t. After edge t: out_vld=1 with the tail flit, ackx=0, busy=0, state IDLE. The earliest next grant is at edge t+1, so there is a minimum 1-cycle ackx gap between packets.
- The granted requester drives flits only while it sees its ackx bit high. A flit presented in the same cycle as the ack edge is not accepted.
- Flits with gaps (flit_vld low mid-packet) are allowed. out_vld follows with one cycle of delay.

## Configuration
- Macro: ARB_WATCHDOG_EN.
- Defined: a counter clears on grant and on every accepted flit, and increments each LOCK cycle with flit_vld[g] low. When it reaches WD_CYCLES, the block releases exactly as on `TAIL, except out_vld stays 0, and pulses wd_err for one cycle. ptr advances to (g+1) mod N.
- Undefined: no counter is built and wd_err is tied to 0. A stalled port holds the link indefinitely.

## Test plan
- Reset then idle: req=0 for 10 cycles -> ackx=0, out_vld=0, ptr=0 throughout.
- Contention: N=4, req=4'b1111 from reset, each port sends HEAD,BODY,TAIL -> grants are in order 0,1,2,3,0. Each packet appears on out_flit intact, with a 1-cycle ackx gap between packets.
- Lock hold: port 1 granted and sends HEAD; port 0 raises req and req[1] drops before TAIL -> ackx stays 4'b0010 until port 1's TAIL. The next grant goes to port 2 if it is requesting, else port 3, else port 0.
- Single-flit packet: port 3 sends one `TAIL flit with payload 8'hA5 -> out_flit={`TAIL,8'hA5} for 1 cycle, and the next grant starts from port 0 (wrap).
- Gapped packet: HEAD, 3 idle cycles, TAIL -> out_vld pattern 1,0,0,0,1. Grant held throughout.
- Watchdog (macro defined, WD_CYCLES=16): port 2 sends HEAD then stalls -> 16 cycles later ackx=0 and wd_err pulses once. Port 3 is granted next if requesting. With the macro undefined, the same stimulus holds ackx=4'b0100 indefinitely.
